// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: load op codes and the width of the
// result bus that MEM hands to WB and to the ID forwarding network.
package mem_stage_pkg;

  // LD_WU and LD_D are only meaningful when the datapath is 64 bits wide.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_H  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4,
    LD_WU = 3'd5,
    LD_D  = 3'd6
  } ld_op_t;

  // The bus carries {we, waddr[4:0], wdata[DATA_W-1:0]}.
  function automatic int rf_bus_w(input int data_w);
    return data_w + 6;
  endfunction

endpackage

// File: rtl/mem_ld_align.sv
// Load data alignment: shift the read beat down to the addressed byte lane,
// then sign- or zero-extend according to the load op.
module mem_ld_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  ld_op_t                        ld_op,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic [DATA_W-1:0]             rdata,
  output logic [DATA_W-1:0]             wdata
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Extend the addressed field to the full datapath width.
  always_comb begin
    wdata = shifted;
    case (ld_op)
      LD_B:  wdata = DATA_W'($signed(shifted[7:0]));
      LD_BU: wdata = DATA_W'(shifted[7:0]);
      LD_H:  wdata = DATA_W'($signed(shifted[15:0]));
      LD_HU: wdata = DATA_W'(shifted[15:0]);
      LD_W:  wdata = DATA_W'($signed(shifted[31:0]));
      LD_WU: wdata = DATA_W'(shifted[31:0]);
      LD_D:  wdata = shifted;
      default: wdata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage between EX and WB. Waits for a variable-latency data_ok
// on loads that issued a request, holds a response in a one-entry buffer while
// WB stalls, and drops responses owed to flushed instructions.
// Optional: define MEM_STAGE_ALE_EN to add the mem_ale misaligned-load output.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ex_mem_valid,
  output logic                          mem_allowin,
  input  logic [31:0]                   ex_pc,
  input  logic [2:0]                    ex_ld_op,
  input  logic                          ex_res_from_mem,
  input  logic                          ex_rf_we,
  input  logic [4:0]                    ex_rf_waddr,
  input  logic [DATA_W-1:0]             ex_alu_result,
  input  logic                          ex_req_sent,
  input  logic                          data_sram_data_ok,
  input  logic [DATA_W-1:0]             data_sram_rdata,
  input  logic                          wb_allowin,
  input  logic                          flush,
  output logic                          mem_wb_valid,
  output logic [31:0]                   mem_pc,
  output logic [rf_bus_w(DATA_W)-1:0]   mem_rf_bus,
  output logic                          mem_ld_wait,
  output logic                          mem_discard_busy
`ifdef MEM_STAGE_ALE_EN
  ,output logic                         mem_ale
`endif
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic              mem_valid_q, mem_valid_d;
  logic              buf_v_q, buf_v_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [CNT_W-1:0]  discard_cnt_q, discard_cnt_d;
  logic [31:0]       pc_q, pc_d;
  ld_op_t            ld_op_q, ld_op_d;
  logic              res_from_mem_q, res_from_mem_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic              req_sent_q, req_sent_d;

  logic              discard_hit, owned_ok, ld_req, waiting, ready_go;
  logic              leaving, capture, rf_we_eff;
  logic [CNT_W:0]    discard_sum;
  logic [DATA_W-1:0] rdata_sel, ld_data, wdata;

  // A response is ours only once every response owed to killed requests is gone.
  assign discard_hit = data_sram_data_ok & (discard_cnt_q != '0);
  assign owned_ok    = data_sram_data_ok & ~discard_hit;
  assign ld_req      = mem_valid_q & res_from_mem_q & req_sent_q;
  assign waiting     = ld_req & ~(owned_ok | buf_v_q);
  assign ready_go    = ~waiting;
  assign mem_allowin = ~mem_valid_q | (ready_go & wb_allowin);
  assign mem_wb_valid = mem_valid_q & ready_go & ~flush;
  assign leaving     = mem_valid_q & ready_go & wb_allowin;
  assign capture     = ex_mem_valid & mem_allowin & ~flush;

  // Wider than the counter so an overrun is visible instead of wrapping.
  assign discard_sum = {1'b0, discard_cnt_q}
                     + (CNT_W+1)'(flush & waiting)
                     + (CNT_W+1)'(flush & ex_mem_valid & ex_req_sent)
                     - (CNT_W+1)'(discard_hit);

  assign rdata_sel = buf_v_q ? buf_data_q : data_sram_rdata;

  mem_ld_align #(.DATA_W(DATA_W)) u_align (
    .ld_op  (ld_op_q),
    .offset (alu_result_q[OFF_W-1:0]),
    .rdata  (rdata_sel),
    .wdata  (ld_data)
  );

  assign wdata = res_from_mem_q ? ld_data : alu_result_q;

`ifdef MEM_STAGE_ALE_EN
  logic misalign;

  // Address must be a multiple of the access size.
  always_comb begin
    misalign = 1'b0;
    case (ld_op_q)
      LD_H, LD_HU:  misalign = alu_result_q[0];
      LD_W, LD_WU:  misalign = |alu_result_q[1:0];
      LD_D:         misalign = |alu_result_q[2:0];
      default:      misalign = 1'b0;
    endcase
  end

  assign mem_ale   = mem_valid_q & res_from_mem_q & misalign;
  assign rf_we_eff = rf_we_q & mem_valid_q & ~mem_ale;
`else
  assign rf_we_eff = rf_we_q & mem_valid_q;
`endif

  assign mem_rf_bus       = {rf_we_eff, rf_waddr_q, wdata};
  assign mem_pc           = pc_q;
  assign mem_ld_wait      = waiting;
  assign mem_discard_busy = (discard_cnt_q != '0);

  // Next-state: stage occupancy, captured EX fields, response buffer, discard count.
  always_comb begin
    mem_valid_d    = mem_valid_q;
    buf_v_d        = buf_v_q;
    buf_data_d     = buf_data_q;
    pc_d           = pc_q;
    ld_op_d        = ld_op_q;
    res_from_mem_d = res_from_mem_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    alu_result_d   = alu_result_q;
    req_sent_d     = req_sent_q;
    discard_cnt_d  = discard_sum[CNT_W-1:0];

    if (flush) begin
      mem_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = ex_mem_valid;
    end

    if (capture) begin
      pc_d           = ex_pc;
      ld_op_d        = ld_op_t'(ex_ld_op);
      res_from_mem_d = ex_res_from_mem;
      rf_we_d        = ex_rf_we;
      rf_waddr_d     = ex_rf_waddr;
      alu_result_d   = ex_alu_result;
      req_sent_d     = ex_req_sent;
    end

    if (flush || leaving) begin
      buf_v_d = 1'b0;
    end else if (ld_req && owned_ok && !buf_v_q) begin
      buf_v_d    = 1'b1;
      buf_data_d = data_sram_rdata;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q    <= 1'b0;
      buf_v_q        <= 1'b0;
      buf_data_q     <= '0;
      discard_cnt_q  <= '0;
      pc_q           <= '0;
      ld_op_q        <= LD_W;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      alu_result_q   <= '0;
      req_sent_q     <= 1'b0;
    end else begin
      mem_valid_q    <= mem_valid_d;
      buf_v_q        <= buf_v_d;
      buf_data_q     <= buf_data_d;
      discard_cnt_q  <= discard_cnt_d;
      pc_q           <= pc_d;
      ld_op_q        <= ld_op_d;
      res_from_mem_q <= res_from_mem_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      alu_result_q   <= alu_result_d;
      req_sent_q     <= req_sent_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: 32-bit instance for most scenarios plus a 64-bit
// instance for the wide load ops. Expected results go into scoreboard queues
// when stimulus is driven and are popped when MEM presents to WB.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [37:0] bus;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_mem_valid, ex_mem_valid64;
  logic [31:0] ex_pc;
  logic [2:0]  ex_ld_op;
  logic        ex_res_from_mem, ex_rf_we, ex_req_sent;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_alu_result;
  logic [63:0] ex_alu64;
  logic        data_ok, data_ok64;
  logic [31:0] rdata;
  logic [63:0] rdata64;
  logic        wb_allowin, flush;

  logic        mem_allowin, mem_wb_valid, mem_ld_wait, mem_discard_busy;
  logic [31:0] mem_pc;
  logic [37:0] mem_rf_bus;
  logic        mem_allowin64, mem_wb_valid64, mem_ld_wait64, mem_discard_busy64;
  logic [31:0] mem_pc64;
  logic [69:0] mem_rf_bus64;
`ifdef MEM_STAGE_ALE_EN
  logic        mem_ale, mem_ale64;
`endif

  exp_t        sb_q[$];
  logic [69:0] sb64_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32), .MAX_OUTST(2)) u_dut (
    .clk(clk), .resetn(resetn),
    .ex_mem_valid(ex_mem_valid), .mem_allowin(mem_allowin),
    .ex_pc(ex_pc), .ex_ld_op(ex_ld_op), .ex_res_from_mem(ex_res_from_mem),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_alu_result(ex_alu_result),
    .ex_req_sent(ex_req_sent), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
    .wb_allowin(wb_allowin), .flush(flush),
    .mem_wb_valid(mem_wb_valid), .mem_pc(mem_pc), .mem_rf_bus(mem_rf_bus),
    .mem_ld_wait(mem_ld_wait), .mem_discard_busy(mem_discard_busy)
`ifdef MEM_STAGE_ALE_EN
    , .mem_ale(mem_ale)
`endif
  );

  mem_access_stage #(.DATA_W(64), .MAX_OUTST(2)) u_dut64 (
    .clk(clk), .resetn(resetn),
    .ex_mem_valid(ex_mem_valid64), .mem_allowin(mem_allowin64),
    .ex_pc(ex_pc), .ex_ld_op(ex_ld_op), .ex_res_from_mem(ex_res_from_mem),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_alu_result(ex_alu64),
    .ex_req_sent(ex_req_sent), .data_sram_data_ok(data_ok64), .data_sram_rdata(rdata64),
    .wb_allowin(wb_allowin), .flush(flush),
    .mem_wb_valid(mem_wb_valid64), .mem_pc(mem_pc64), .mem_rf_bus(mem_rf_bus64),
    .mem_ld_wait(mem_ld_wait64), .mem_discard_busy(mem_discard_busy64)
`ifdef MEM_STAGE_ALE_EN
    , .mem_ale(mem_ale64)
`endif
  );

  // The discard counter must never be asked to go past MAX_OUTST.
  always @(negedge clk) begin
    if (resetn) begin
      assert (u_dut.discard_sum <= 2 && u_dut64.discard_sum <= 2)
        else $error("discard counter overrun");
    end
  end

  task automatic idle();
    ex_mem_valid = 1'b0; ex_mem_valid64 = 1'b0;
    data_ok = 1'b0; data_ok64 = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [2:0] op, input logic rfm,
                       input logic we, input logic [4:0] wa, input logic [31:0] addr,
                       input logic sent);
    ex_mem_valid = 1'b1; ex_pc = pc; ex_ld_op = op; ex_res_from_mem = rfm;
    ex_rf_we = we; ex_rf_waddr = wa; ex_alu_result = addr; ex_req_sent = sent;
  endtask

  task automatic test_reset();
    resetn = 1'b0; idle(); wb_allowin = 1'b1; rdata = '0; rdata64 = '0;
    ex_pc = '0; ex_ld_op = '0; ex_res_from_mem = 0; ex_rf_we = 0;
    ex_rf_waddr = '0; ex_alu_result = '0; ex_alu64 = '0; ex_req_sent = 0;
    repeat (2) @(negedge clk);
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL rst_allowin got=%b want=1", mem_allowin); end
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b want=0", mem_wb_valid); end
    total++; if (mem_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", mem_pc); end
    total++; if (mem_rf_bus !== 38'h0) begin bad++; $display("FAIL rst_bus got=%h want=0", mem_rf_bus); end
    total++; if (mem_ld_wait !== 1'b0 || mem_discard_busy !== 1'b0) begin
      bad++; $display("FAIL rst_wait_busy got=%b%b want=00", mem_ld_wait, mem_discard_busy); end
    @(posedge clk); #1 resetn = 1'b1;
    // A load left waiting must be cleared by an asynchronous reset mid-cycle.
    @(posedge clk); #1 issue(32'h700, LD_W, 1, 1, 5'd2, 32'h0, 1);
    @(posedge clk); #1 idle();
    @(negedge clk);
    total++; if (mem_ld_wait !== 1'b1) begin bad++; $display("FAIL rst_pre_wait got=%b want=1", mem_ld_wait); end
    #2 resetn = 1'b0;
    #1;
    total++; if (mem_ld_wait !== 1'b0 || mem_pc !== 32'h0 || mem_allowin !== 1'b1) begin
      bad++; $display("FAIL rst_async got wait=%b pc=%h allowin=%b want 0/0/1", mem_ld_wait, mem_pc, mem_allowin); end
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  task automatic test_ld_b();
    exp_t e;
    @(posedge clk); #1 wb_allowin = 1'b1;
    issue(32'h100, LD_B, 1, 1, 5'd5, 32'h1003, 1);
    sb_q.push_back('{pc: 32'h100, bus: {1'b1, 5'd5, 32'hFFFF_FF80}});
    @(posedge clk); #1 ex_mem_valid = 1'b0;
    @(negedge clk);
    total++; if (mem_wb_valid !== 1'b0 || mem_ld_wait !== 1'b1) begin
      bad++; $display("FAIL ldb_wait got valid=%b wait=%b want 0/1", mem_wb_valid, mem_ld_wait); end
    @(posedge clk); #1 data_ok = 1'b1; rdata = 32'h80FF_0000;
    @(negedge clk);
    total++; if (mem_wb_valid !== 1'b1) begin bad++; $display("FAIL ldb_valid got=%b want=1", mem_wb_valid); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL ldb_sb_empty got=empty want=entry"); end
    else begin
      e = sb_q.pop_front();
      if (mem_rf_bus !== e.bus || mem_pc !== e.pc) begin
        bad++; $display("FAIL ldb_data got bus=%h pc=%h want bus=%h pc=%h", mem_rf_bus, mem_pc, e.bus, e.pc); end
    end
    @(posedge clk); #1 data_ok = 1'b0; rdata = '0;
    @(negedge clk);
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL ldb_after got=%b want=0", mem_wb_valid); end
  endtask

  task automatic test_ld_hu_stall();
    exp_t e;
    @(posedge clk); #1 wb_allowin = 1'b0;
    issue(32'h200, LD_HU, 1, 1, 5'd7, 32'h2, 1);
    sb_q.push_back('{pc: 32'h200, bus: {1'b1, 5'd7, 32'h0000_ABCD}});
    @(posedge clk); #1 ex_mem_valid = 1'b0; data_ok = 1'b1; rdata = 32'hABCD_1234;
    @(negedge clk);
    total++; if (mem_wb_valid !== 1'b1 || mem_rf_bus !== sb_q[0].bus) begin
      bad++; $display("FAIL hu_live got valid=%b bus=%h want 1/%h", mem_wb_valid, mem_rf_bus, sb_q[0].bus); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 data_ok = 1'b0; rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      total++; if (mem_wb_valid !== 1'b1 || mem_rf_bus !== sb_q[0].bus) begin
        bad++; $display("FAIL hu_hold%0d got valid=%b bus=%h want 1/%h", k, mem_wb_valid, mem_rf_bus, sb_q[0].bus); end
    end
    @(posedge clk); #1 wb_allowin = 1'b1;
    @(negedge clk);
    total++;
    e = sb_q.pop_front();
    if (mem_wb_valid !== 1'b1 || mem_rf_bus !== e.bus || mem_pc !== e.pc) begin
      bad++; $display("FAIL hu_accept got valid=%b bus=%h pc=%h want 1/%h/%h", mem_wb_valid, mem_rf_bus, mem_pc, e.bus, e.pc); end
    @(posedge clk); #1 rdata = '0;
    @(negedge clk);
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL hu_gone got=%b want=0", mem_wb_valid); end
  endtask

  task automatic test_flush_discard();
    exp_t e;
    @(posedge clk); #1 wb_allowin = 1'b1;
    issue(32'h300, LD_W, 1, 1, 5'd3, 32'h0, 1);
    @(posedge clk); #1 issue(32'h304, LD_W, 1, 1, 5'd4, 32'h4, 1); flush = 1'b1;
    @(negedge clk);
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL fl_kill got=%b want=0", mem_wb_valid); end
    @(posedge clk); #1 flush = 1'b0; issue(32'h400, LD_W, 1, 1, 5'd9, 32'h0, 1);
    sb_q.push_back('{pc: 32'h400, bus: {1'b1, 5'd9, 32'h3333_3333}});
    @(negedge clk);
    total++; if (mem_discard_busy !== 1'b1 || u_dut.discard_cnt_q !== 2'd2) begin
      bad++; $display("FAIL fl_cnt got busy=%b cnt=%0d want 1/2", mem_discard_busy, u_dut.discard_cnt_q); end
    @(posedge clk); #1 ex_mem_valid = 1'b0; data_ok = 1'b1; rdata = 32'h1111_1111;
    @(negedge clk);
    total++; if (mem_wb_valid !== 1'b0 || mem_ld_wait !== 1'b1) begin
      bad++; $display("FAIL fl_drop1 got valid=%b wait=%b want 0/1", mem_wb_valid, mem_ld_wait); end
    @(posedge clk); #1 rdata = 32'h2222_2222;
    @(negedge clk);
    total++; if (mem_wb_valid !== 1'b0 || mem_discard_busy !== 1'b1) begin
      bad++; $display("FAIL fl_drop2 got valid=%b busy=%b want 0/1", mem_wb_valid, mem_discard_busy); end
    @(posedge clk); #1 rdata = 32'h3333_3333;
    @(negedge clk);
    total++;
    e = sb_q.pop_front();
    if (mem_discard_busy !== 1'b0 || mem_wb_valid !== 1'b1 || mem_rf_bus !== e.bus || mem_pc !== e.pc) begin
      bad++; $display("FAIL fl_deliver got busy=%b valid=%b bus=%h pc=%h want 0/1/%h/%h",
                      mem_discard_busy, mem_wb_valid, mem_rf_bus, mem_pc, e.bus, e.pc); end
    @(posedge clk); #1 data_ok = 1'b0; rdata = '0;
    @(negedge clk);
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL fl_after got=%b want=0", mem_wb_valid); end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] v;
    @(posedge clk); #1 wb_allowin = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i < 6) begin
        v = $urandom;
        issue(32'h500 + 32'(4*i), LD_B, 0, 1, 5'(i+1), v, 0);
        sb_q.push_back('{pc: 32'h500 + 32'(4*i), bus: {1'b1, 5'(i+1), v}});
      end else begin
        ex_mem_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        total++;
        e = sb_q.pop_front();
        if (mem_wb_valid !== 1'b1 || mem_ld_wait !== 1'b0 || mem_allowin !== 1'b1 ||
            mem_rf_bus !== e.bus || mem_pc !== e.pc) begin
          bad++; $display("FAIL b2b%0d got valid=%b wait=%b allowin=%b bus=%h pc=%h want 1/0/1/%h/%h",
                          i, mem_wb_valid, mem_ld_wait, mem_allowin, mem_rf_bus, mem_pc, e.bus, e.pc); end
      end
    end
  endtask

  task automatic test_ld_64();
    logic [2:0]  ops [3];
    logic [63:0] addrs [3];
    logic [63:0] rds [3];
    logic [63:0] exps [3];
    logic [69:0] eb;
    ops[0] = LD_WU; addrs[0] = 64'h4; rds[0] = 64'h8765_4321_0000_0000; exps[0] = 64'h0000_0000_8765_4321;
    ops[1] = LD_W;  addrs[1] = 64'h0; rds[1] = 64'h0000_0000_8000_0001; exps[1] = 64'hFFFF_FFFF_8000_0001;
    ops[2] = LD_D;  addrs[2] = 64'h8; rds[2] = 64'h0123_4567_89AB_CDEF; exps[2] = 64'h0123_4567_89AB_CDEF;
    wb_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1
      ex_mem_valid64 = 1'b1; ex_pc = 32'h800 + 32'(i); ex_ld_op = ops[i]; ex_res_from_mem = 1'b1;
      ex_rf_we = 1'b1; ex_rf_waddr = 5'(10+i); ex_alu64 = addrs[i]; ex_req_sent = 1'b1;
      sb64_q.push_back({1'b1, 5'(10+i), exps[i]});
      @(posedge clk); #1 ex_mem_valid64 = 1'b0; data_ok64 = 1'b1; rdata64 = rds[i];
      @(negedge clk);
      total++;
      eb = sb64_q.pop_front();
      if (mem_wb_valid64 !== 1'b1 || mem_rf_bus64 !== eb) begin
        bad++; $display("FAIL ld64_%0d got valid=%b bus=%h want 1/%h", i, mem_wb_valid64, mem_rf_bus64, eb); end
      @(posedge clk); #1 data_ok64 = 1'b0; rdata64 = '0;
    end
  endtask

  task automatic test_misalign();
    exp_t e;
`ifdef MEM_STAGE_ALE_EN
    @(posedge clk); #1 wb_allowin = 1'b1; rdata = 32'hAABB_CCDD;
    issue(32'h600, LD_W, 1, 1, 5'd6, 32'h2, 0);
    sb_q.push_back('{pc: 32'h600, bus: {1'b0, 5'd6, 32'h0000_AABB}});
    @(posedge clk); #1 ex_mem_valid = 1'b0;
    @(negedge clk);
    total++;
    e = sb_q.pop_front();
    if (mem_ale !== 1'b1 || mem_wb_valid !== 1'b1 || mem_ld_wait !== 1'b0 || mem_rf_bus !== e.bus) begin
      bad++; $display("FAIL ale got ale=%b valid=%b wait=%b bus=%h want 1/1/0/%h",
                      mem_ale, mem_wb_valid, mem_ld_wait, mem_rf_bus, e.bus); end
    @(posedge clk); #1 rdata = '0;
`else
    @(posedge clk); #1 wb_allowin = 1'b1;
    issue(32'h600, LD_W, 1, 1, 5'd6, 32'h2, 1);
    sb_q.push_back('{pc: 32'h600, bus: {1'b1, 5'd6, 32'h0000_AABB}});
    @(posedge clk); #1 ex_mem_valid = 1'b0; data_ok = 1'b1; rdata = 32'hAABB_CCDD;
    @(negedge clk);
    total++;
    e = sb_q.pop_front();
    if (mem_wb_valid !== 1'b1 || mem_rf_bus !== e.bus || mem_pc !== e.pc) begin
      bad++; $display("FAIL misalign got valid=%b bus=%h want 1/%h", mem_wb_valid, mem_rf_bus, e.bus); end
    @(posedge clk); #1 data_ok = 1'b0; rdata = '0;
`endif
  endtask

  initial begin
    test_reset();
    test_ld_b();
    test_ld_hu_stall();
    test_flush_discard();
    test_back_to_back();
    test_ld_64();
    test_misalign();
    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0 || sb64_q.size() != 0) begin
      bad++; $display("FAIL sb_drain got=%0d/%0d want=0/0", sb_q.size(), sb64_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM pipeline stage for the LoongArch core, sitting between EX and WB. It accepts one instruction per cycle from EX and waits for a variable-latency `data_ok` when a load request was issued. It aligns and extends load data for any `DATA_W`, buffers a response that arrives while WB stalls, and discards responses that belong to flushed instructions.

## Interface
Parameters:
- `DATA_W`, 32: datapath and SRAM read width; legal values 32 or 64.
- `MAX_OUTST`, 2: maximum killed in-flight requests tracked for discard; at least 2.

Ports:
- `clk`  in  1  core clock.
- `resetn`  in  1  reset; one clock; asynchronous and active-low.
- `ex_mem_valid`  in  1  EX holds a valid instruction for MEM.
- `mem_allowin`  out  1  MEM accepts from EX this cycle.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_ld_op`  in  3  load op code (package `LD_*`).
- `ex_res_from_mem`  in  1  write-back data comes from memory.
- `ex_rf_we`  in  1  register write enable.
- `ex_rf_waddr`  in  5  destination register.
- `ex_alu_result`  in  DATA_W  ALU result or memory address.
- `ex_req_sent`  in  1  EX issued a data SRAM request for this instruction.
- `data_sram_data_ok`  in  1  one response beat returned.
- `data_sram_rdata`  in  DATA_W  response data.
- `wb_allowin`  in  1  WB accepts.
- `flush`  in  1  kill MEM and EX contents this cycle.
- `mem_wb_valid`  out  1  MEM presents a finished instruction to WB.
- `mem_pc`  out  32  PC of the MEM instruction.
- `mem_rf_bus`  out  6+DATA_W  {we&valid, waddr, wdata}; also used as the forwarding source.
- `mem_ld_wait`  out  1  valid load still awaiting data; ID must stall on a RAW hazard.
- `mem_discard_busy`  out  1  discard counter non-zero; EX must not issue new requests.

## Operation
- Load ops: `LD_W`, `LD_B`, `LD_H`, `LD_BU`, and `LD_HU` always exist. `LD_WU` and `LD_D` exist only when `DATA_W`=64.
- Extraction: shift `rdata` right by `addr[log2(DATA_W/8)-1:0]*8`. Sign-extend or zero-extend from bit 7, 15 or 31 to DATA_W. `LD_D` passes the data through unchanged. On 64-bit, `LD_W` sign-extends.
- Waiting condition: `waiting = mem_valid & res_from_mem & req_sent & ~got`. Here `got` = `data_ok` for this instruction this cycle, or the buffer is valid.
- `ready_go = ~waiting`.
- `mem_allowin = ~mem_valid | ready_go & wb_allowin`.
- `mem_wb_valid = mem_valid & ready_go & ~flush`.
- Response buffer: when `data_ok` belongs to MEM and the instruction does not leave this cycle, capture `rdata` and set `buf_v`. `buf_v` clears when the instruction leaves or on flush. `wdata` uses the buffered data when `buf_v` is set, otherwise the live `rdata`.
- Response ownership: a `data_ok` while `discard_cnt`>0 decrements the counter and is dropped. Otherwise it belongs to the MEM instruction.
- Flush handling: `mem_valid` clears and `buf_v` clears. `discard_cnt` increases by the sum of two terms:
  - (MEM waiting and no owned `data_ok` this cycle);
  - (`ex_mem_valid & ex_req_sent`).
  - A simultaneous discard decrement is applied in the same cycle.
  - Saturation never occurs by contract; a bench assertion fires if `discard_cnt` would exceed `MAX_OUTST`.
- Capture: when `ex_mem_valid & mem_allowin & ~flush`, all `ex_*` fields are captured.

## Timing
- Reset values:
  - `mem_valid` = 0, `buf_v` = 0, `discard_cnt` = 0.
  - `mem_pc` = 0, all captured fields = 0.
  - Hence all outputs are 0, except `mem_allowin` = 1.
- Latency:
  - Non-load, or a load with `ex_req_sent`=0: present to WB the cycle after capture.
  - Load with a request: presented in the cycle `data_ok` arrives (combinational `rdata` path) or later.
- Reset asserted mid-operation clears all state immediately. Outstanding responses after reset are the system's responsibility.

## Configuration
- `MEM_STAGE_ALE_EN` defined:
  - Adds output `mem_ale` (1 bit), asserted for a valid load whose address is misaligned for its size.
  - `mem_ale` gates off `rf_we` in `mem_rf_bus`.
  - EX guarantees `ex_req_sent`=0 for such loads.
- Undefined: no `mem_ale` port; no alignment check; misaligned addresses read the shifted bytes as-is.

## Structure
- Package `mem_stage_pkg`: `LD_*` codes, `ld_op_t` (3-bit), and a bus-width function for `mem_rf_bus`.
- Sub-module `mem_ld_align`: combinational shift and extend, parametrised by `DATA_W`, instantiated once.

## Test plan
- `LD_B` at address 0x1003, `rdata` 0x80FF_0000 returned 2 cycles after capture → `wdata` 0xFFFF_FF80; `mem_wb_valid` is high only in the `data_ok` cycle.
- `LD_HU` at address 0x2, `data_ok` with `wb_allowin`=0 for 3 cycles, `rdata` 0xABCD_1234 → buffered; `wdata` 0x0000_ABCD held until WB accepts.
- Flush while a MEM load waits and EX holds a sent request → `discard_cnt`=2; the next two `data_ok` are dropped; the third is delivered to the new load.
- `DATA_W`=64, `LD_WU` at address 0x4, `rdata` 0x8765_4321_0000_0000 → `wdata` 0x0000_0000_8765_4321.
- With `MEM_STAGE_ALE_EN`, `LD_W` at address 0x2 → `mem_ale`=1, `rf_we`=0, presented the next cycle without waiting.
- ALU-op back-to-back stream, `wb_allowin`=1 → one instruction retired per cycle, `mem_ld_wait`=0 throughout.
